// File: rtl/bcd_down_counter_if.sv
// Load/count bundle for the BCD down counter.
// master drives the load and enable side; slave is the counter itself.
interface bcd_down_counter_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  enable;
    logic [4*DIGITS-1:0]   count;
    logic                  zero;
    logic                  tc;
    logic                  load_err;

    modport master (
        output load, load_value, enable,
        input  count, zero, tc, load_err
    );

    modport slave (
        input  load, load_value, enable,
        output count, zero, tc, load_err
    );
endinterface

// File: rtl/bcd_down_counter.sv
// Multi-digit packed-BCD down counter with clamped parallel load, zero flag and tc pulse.
// Optional feature: define BCD_DOWN_AUTO_RELOAD_EN to reload the last loaded value at zero.
module bcd_down_counter #(
    parameter int unsigned DIGITS = 2
) (
    input logic              clock,
    input logic              clear,
    bcd_down_counter_if.slave bus
);
    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] clamped;
    logic [W-1:0] decremented;
    logic         bad_digit;
    logic         borrow;
    logic         tc_q, tc_d;
    logic         load_err_q, load_err_d;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
    logic [W-1:0] reload_q, reload_d;
`endif

    // Out-of-range digits are forced to 9 so the count never holds a non-BCD digit.
    always_comb begin
        clamped   = '0;
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.load_value[4*i +: 4] > 4'd9) begin
                clamped[4*i +: 4] = 4'd9;
                bad_digit         = 1'b1;
            end else begin
                clamped[4*i +: 4] = bus.load_value[4*i +: 4];
            end
        end
    end

    always_comb begin
        decremented = count_q;
        borrow      = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    decremented[4*i +: 4] = 4'd9;
                end else begin
                    decremented[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow                = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
        reload_d   = reload_q;
`endif
        if (bus.load) begin
            count_d    = clamped;
            load_err_d = bad_digit;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            reload_d   = clamped;
`endif
        end else if (bus.enable) begin
            if (count_q != '0) begin
                count_d = decremented;
                tc_d    = (count_q == W'(1));
            end else begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                // A zero reload value reproduces the plain hold-at-zero behaviour.
                count_d = reload_q;
`else
                count_d = count_q;
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            reload_q   <= '0;
`endif
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            reload_q   <= reload_d;
`endif
        end
    end

    assign bus.count    = count_q;
    assign bus.zero     = (count_q == '0);
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;
endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Multi-digit BCD down counter (countdown timer) with parallel load, count enable, zero flag and terminal-count pulse.
- Counts in the opposite direction to the team's BCD up counter and consumes the same packed-BCD digit format, low digit in bits [3:0].
- Used for countdown/timeout functions that feed BCD display paths directly, with no binary conversion.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS.

Ports:
- clock  input  1  system clock, rising-edge active.
- clear  input  1  asynchronous, active-high reset.
- load  input  1  parallel load strobe, sampled on the rising clock edge.
- load_value  input  4*DIGITS  packed BCD load value; digit i occupies bits [4i+3:4i].
- enable  input  1  count enable (level); one decrement per enabled cycle.
- count  output  4*DIGITS  current packed BCD count (registered).
- zero  output  1  high whenever count == 0; combinational decode of the count register.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- load_err  output  1  invalid-digit flag on load, registered, one cycle wide.

Behaviour:
- Clock and reset: one clock domain. clear is asynchronous and active-high; it overrides everything at any time, including mid-count.
- Reset values: count=0, zero=1, tc=0, load_err=0. The reload register (when the optional feature is enabled) is also 0.
- Priority per edge: clear > load > enable > hold.
- Load:
  - count <= load_value, digit-wise.
  - Any digit > 9 (A..F) is clamped to 9 and load_err=1 for the following cycle. Otherwise load_err=0.
  - A load never asserts tc, even when load_value=0.
  - load and enable in the same cycle: the load wins and no decrement occurs.
- Decrement (enable=1, load=0, count != 0):
  - Digit 0 decrements by 1.
  - A digit at 0 that receives a borrow becomes 9 and passes the borrow to the next digit up.
  - The borrow chain stops at the first nonzero digit.
  - Example: 0x100 -> 0x099.
- tc: set to 1 on the edge where count goes from 0...01 to 0 via decrement; 0 on all other edges. tc is therefore high during the first cycle in which count reads 0.
- At zero, enable=1, feature off: count holds at 0 (no wrap to 99..9), tc=0, zero stays 1.
- enable=0: count holds; tc=0.
- Latency: count updates 1 cycle after the sampling edge. zero follows count with no extra delay. tc and load_err are aligned with the count update they describe.
- Digit invariant: count digits never exceed 9 in any reachable state.

Optional Feature:
- Macro: BCD_DOWN_AUTO_RELOAD_EN.
- Defined:
  - A reload register captures the post-clamp value of every accepted load; it resets to 0 on clear.
  - When enable=1, load=0, count==0 and the reload register is nonzero, the counter reloads: count <= reload register on that edge.
  - tc is not asserted on a reload edge; it already fired on the edge that reached 0.
  - A zero-valued reload register behaves as the feature-off case (hold at 0).
- Undefined: the reload register is absent and count holds at 0 as described above.

Test Plan (DIGITS=2):
- Reset mid-count: load 0x35, enable 3 cycles (count 0x32), assert clear asynchronously between edges -> count=0x00, zero=1, tc=0 immediately, without waiting for an edge.
- Borrow chain: load 0x10, enable 1 cycle -> count=0x09. Next enable -> count=0x08. No tc, zero=0.
- Terminal count: load 0x02, enable continuously -> count 0x01, then 0x00 with tc=1 for exactly that one cycle. Further enables -> count holds 0x00, tc=0 (feature off).
- Invalid load: load_value=0xA7 -> count=0x97, load_err=1 for 1 cycle then 0. load_value=0x42 -> count=0x42, load_err=0.
- Load/enable collision: count=0x50, load=1 with load_value=0x20 and enable=1 in the same cycle -> count=0x20 (no decrement). load 0x00 -> zero=1, tc=0.
- Auto-reload (macro defined): load 0x03, enable continuously -> 0x02, 0x01, 0x00 (tc=1), then 0x03 (tc=0), then 0x02. After clear, enable at zero -> count holds 0x00.
